// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. It generates word-aligned PCs, issues
//   reads to a 1-cycle-latency instruction memory and buffers {instr, pc}.
// Latency: request in cycle N, head visible in N+2. With FETCH_QUEUE_BYPASS_EN
//   defined, a response that finds the queue empty is visible in N+1.
// Backpressure: credit based. A read is issued only while
//   count + inflight < DEPTH. out_ready low fills the queue and then stalls fetch.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue response bypass).
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   imem_req/addr    read strobe and word-aligned byte address (the fetch PC)
//   imem_rdata       read data, valid the cycle after imem_req
//   out_valid/ready  head-of-queue handshake toward decode/execute
//   out_instr/pc     head instruction and its PC (hold last head when empty)
//   redirect/_pc     flush queue and in-flight read, restart at redirect_pc
//   count            queue occupancy, 0..DEPTH

module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   r_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;

    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    // Last head presented; drives the outputs while the queue is empty so
    // they never show stale storage or X.
    logic [31:0]   r_last_instr;
    logic [31:0]   r_last_pc;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [CW-1:0] w_used;
    logic          w_issue;
    logic          w_fifo_nonempty;
    logic          w_bypass_vld;
    logic          w_bypass_take;
    logic          w_pop;
    logic          w_push;
    logic          w_wr_en;

    // Credit: entries held plus the one read that may still land. A pop in
    // this cycle is deliberately not credited, which keeps imem_req free of
    // any path from out_ready.
    assign w_used  = r_count + {{(CW-1){1'b0}}, r_inflight};
    assign w_issue = !rst && (w_used < CW'(DEPTH));

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    assign w_fifo_nonempty = (r_count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // A response landing on an empty queue is shown directly. A redirect in
    // the same cycle kills it, because that response belongs to the old stream.
    assign w_bypass_vld = !w_fifo_nonempty && r_inflight && !redirect;
`else
    assign w_bypass_vld = 1'b0;
`endif

    assign w_bypass_take = w_bypass_vld && out_ready;

    assign out_valid = w_fifo_nonempty || w_bypass_vld;

    always_comb begin
        out_instr = r_last_instr;
        out_pc    = r_last_pc;
        if (w_fifo_nonempty) begin
            out_instr = r_mem_instr[r_rd_ptr];
            out_pc    = r_mem_pc[r_rd_ptr];
        end else if (w_bypass_vld) begin
            out_instr = imem_rdata;
            out_pc    = r_inflight_pc;
        end
    end

    // Only pops from storage move the read pointer. A consumed bypass entry
    // is simply never written.
    assign w_pop   = w_fifo_nonempty && out_ready;
    assign w_push  = r_inflight && !w_bypass_take;
    assign w_wr_en = w_push && !redirect;

    // ------------------------------------------------------------------
    // Queue storage. It needs no reset because occupancy gates every read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_instr[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    // ------------------------------------------------------------------
    // PC, in-flight tracking, pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= PC_RESET & 32'hFFFF_FFFC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_last_instr  <= 32'h0;
            r_last_pc     <= 32'h0;
        end else begin
            if (out_valid) begin
                r_last_instr <= out_instr;
                r_last_pc    <= out_pc;
            end

            if (redirect) begin
                // Flush wins over everything. Any head handshake this cycle is
                // treated as consumed. The read issued this cycle, if any,
                // lands with r_inflight low and is dropped.
                r_pc       <= redirect_pc & 32'hFFFF_FFFC;
                r_inflight <= 1'b0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue) begin
                    r_inflight    <= 1'b1;
                    r_inflight_pc <= r_pc;
                    r_pc          <= r_pc + 32'd4;
                end else begin
                    r_inflight    <= 1'b0;
                end

                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end

                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue (reset, streaming, backpressure,
//   redirect, PC wrap, random out_ready ordering). The memory model returns the
//   address as data one cycle after the request.

module tb_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [2:0]  count;

    // Second instance for the PC wrap scenario.
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata = 32'h0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic [2:0]  w_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata   <= imem_addr;
    always @(posedge clk) w_imem_rdata <= w_imem_addr;

    fetch_queue #(.DEPTH(DEPTH), .PC_RESET(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .count(count)
    );

    fetch_queue #(.DEPTH(DEPTH), .PC_RESET(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc), .count(w_count)
    );

    // Reset pulse; returns #1 after the negedge that releases rst (cycle 0).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            exp = 32'(4 * c);
            checks++; if (imem_req !== 1'b1 || imem_addr !== exp) begin
                failures++; $display("FAIL stream_req c=%0d got=%b/%h exp=1/%h", c, imem_req, imem_addr, exp); end
            checks++; if (out_valid !== (c >= LAT)) begin
                failures++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, out_valid, (c >= LAT)); end
            if (c >= LAT) begin
                exp = 32'(4 * (c - LAT));
                checks++; if (out_pc !== exp || out_instr !== exp) begin
                    failures++; $display("FAIL stream_head c=%0d got=%h/%h exp=%h", c, out_pc, out_instr, exp); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            checks++; if (count > 3'd4) begin
                failures++; $display("FAIL bp_overflow c=%0d got=%0d exp<=4", c, count); end
            @(negedge clk);
        end
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL bp_full_count got=%0d exp=4", count); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_stall_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL bp_stall_addr got=%h exp=10", imem_addr); end
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            exp = 32'(4 * c);
            checks++; if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== exp) begin
                failures++; $display("FAIL bp_drain c=%0d got=%b/%h/%h exp=1/%h", c, out_valid, out_pc, out_instr, exp); end
            if (c == 1) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
                    failures++; $display("FAIL bp_resume got=%b/%h exp=1/10", imem_req, imem_addr); end
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp;
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) @(negedge clk);
        #1;
        // Cycle 4: three entries held, read for 0xC in flight.
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL redir_pre_count got=%0d exp=3", count); end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL redir_count got=%0d exp=0", count); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++; $display("FAIL redir_addr got=%b/%h exp=1/100", imem_req, imem_addr); end
        exp = 32'h100;
        for (int c = 1; c < 7; c++) begin
            checks++; if (out_valid !== (c >= LAT + 1)) begin
                failures++; $display("FAIL redir_valid c=%0d got=%b exp=%b", c, out_valid, (c >= LAT + 1)); end
            if (out_valid === 1'b1) begin
                checks++; if (out_pc !== exp || out_instr !== exp) begin
                    failures++; $display("FAIL redir_head c=%0d got=%h/%h exp=%h", c, out_pc, out_instr, exp); end
                exp = exp + 32'd4;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] base;
        logic [31:0] exp;
        base = 32'hFFFF_FFF8;
        do_reset();
        for (int c = 0; c < LAT + 4; c++) begin
            exp = base + 32'(4 * c);
            checks++; if (w_imem_addr !== exp) begin
                failures++; $display("FAIL wrap_addr c=%0d got=%h exp=%h", c, w_imem_addr, exp); end
            if (c >= LAT) begin
                exp = base + 32'(4 * (c - LAT));
                checks++; if (w_out_valid !== 1'b1 || w_out_pc !== exp) begin
                    failures++; $display("FAIL wrap_head c=%0d got=%b/%h exp=1/%h", c, w_out_valid, w_out_pc, exp); end
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 5; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL mid_rst_state got=%b/%0d exp=0/0", out_valid, count); end
        checks++; if (imem_addr !== 32'h0 || out_instr !== 32'h0) begin
            failures++; $display("FAIL mid_rst_regs got=%h/%h exp=0/0", imem_addr, out_instr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (imem_addr !== 32'(4 * c)) begin
                failures++; $display("FAIL mid_rst_addr c=%0d got=%h exp=%h", c, imem_addr, 32'(4 * c)); end
            checks++; if (out_valid !== (c >= LAT)) begin
                failures++; $display("FAIL mid_rst_valid c=%0d got=%b exp=%b", c, out_valid, (c >= LAT)); end
            if (c >= LAT) begin
                checks++; if (out_pc !== 32'(4 * (c - LAT))) begin
                    failures++; $display("FAIL mid_rst_head c=%0d got=%h exp=%h", c, out_pc, 32'(4 * (c - LAT))); end
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_random_ready();
        logic [31:0] exp;
        int          pops;
        exp  = 32'h0;
        pops = 0;
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (count > 3'd4) begin
                failures++; $display("FAIL rand_count c=%0d got=%0d exp<=4", c, count); end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++; if (out_pc !== exp || out_instr !== exp) begin
                    failures++; $display("FAIL rand_order c=%0d got=%h/%h exp=%h", c, out_pc, out_instr, exp); end
                exp = exp + 32'd4;
                pops++;
            end
            @(negedge clk);
        end
        checks++; if (pops < 400) begin
            failures++; $display("FAIL rand_throughput got=%0d exp>=400", pops); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_midstream();
        test_random_ready();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
